// File: rtl/vga_timing_pkg.sv
// Raster mode descriptors and helpers for the
// VGA/HDMI timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33
  };

  localparam vga_mode_t MODE_800x600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23
  };

  function automatic int h_total(vga_mode_t m);
    return m.h_active + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic int v_total(vga_mode_t m);
    return m.v_active + m.v_fp + m.v_sync + m.v_bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-gated delay line for the sync/DE bundle;
// flush and reset both load the idle pattern.
module vga_sync_delay #(
  parameter int W = 5,
  parameter int LAT = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [LAT];

  always_ff @(posedge clk) begin
    if (reset || (en && flush)) begin
      for (int i = 0; i < LAT; i++) stg[i] <= INIT;
    end else if (en) begin
      stg[0] <= d;
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[LAT-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, restart handling and sync decode;
// sync/DE are delayed to align with framebuffer reads.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_640x480_60.h_active,
  parameter int H_FP     = MODE_640x480_60.h_fp,
  parameter int H_SYNC   = MODE_640x480_60.h_sync,
  parameter int H_BP     = MODE_640x480_60.h_bp,
  parameter int V_ACTIVE = MODE_640x480_60.v_active,
  parameter int V_FP     = MODE_640x480_60.v_fp,
  parameter int V_SYNC   = MODE_640x480_60.v_sync,
  parameter int V_BP     = MODE_640x480_60.v_bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LAT      = 2,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          restart,
  output logic [CW-1:0] x_pixel,
  output logic [CW-1:0] y_pixel,
  output logic          fetch_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic          frame_start,
  output logic          line_start,
  output logic [15:0]   frame_cnt
);

  localparam vga_mode_t MODE = '{
    h_active: H_ACTIVE, h_fp: H_FP,
    h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP,
    v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int H_TOTAL = h_total(MODE);
  localparam int V_TOTAL = v_total(MODE);

  if ((2**CW) < H_TOTAL || (2**CW) < V_TOTAL) begin : g_cw_chk
    $error("vga_timing_gen: CW too small");
  end
  if (LAT < 1 || LAT > 8) begin : g_lat_chk
    $error("vga_timing_gen: LAT out of 1..8");
  end

  localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_END = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_END = CW'(V_TOTAL - 1);
  localparam logic [4:0]    IDLE  = {~HS_POL, ~VS_POL, 3'b000};

  logic [CW-1:0] h_cnt, v_cnt;
  logic          pend, go_rst;
  logic          hs_raw, vs_raw, fs_raw, ls_raw;
  logic [4:0]    raw, dly;

  // a restart seen between ticks is held until the next tick
  assign go_rst = restart | pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      pend      <= 1'b0;
    end else if (pix_en) begin
      pend <= 1'b0;
      if (go_rst) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == H_END) begin
        h_cnt <= '0;
        if (v_cnt == V_END) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else if (restart) begin
      pend <= 1'b1;
    end
  end

  assign fetch_en = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= H_SS && h_cnt < H_SE) ? HS_POL : ~HS_POL;
  assign vs_raw = (v_cnt >= V_SS && v_cnt < V_SE) ? VS_POL : ~VS_POL;
  assign fs_raw = (h_cnt == '0) && (v_cnt == '0);
  assign ls_raw = (h_cnt == '0) && (v_cnt < V_ACT);
  assign raw = {hs_raw, vs_raw, fetch_en, fs_raw, ls_raw};

  vga_sync_delay #(
    .W(5),
    .LAT(LAT),
    .INIT(IDLE)
  ) u_dly (
    .clk(clk),
    .reset(reset),
    .en(pix_en),
    .flush(go_rst),
    .d(raw),
    .q(dly)
  );

  assign x_pixel     = h_cnt;
  assign y_pixel     = v_cnt;
  assign h_sync      = dly[4];
  assign v_sync      = dly[3];
  assign de          = dly[2];
  assign frame_start = dly[1] & pix_en;
  assign line_start  = dly[0] & pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode plus a small
// inverted-polarity LAT=5 mode against a position-history model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic reset, pix_en, restart;
  always #5 clk = ~clk;

  logic [10:0] x0, y0;
  logic [3:0]  x1, y1;
  logic        fe0, hs0, vs0, de0, fs0, ls0;
  logic        fe1, hs1, vs1, de1, fs1, ls1;
  logic [15:0] fc0, fc1;

  vga_timing_gen dut0 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .restart(restart),
    .x_pixel(x0), .y_pixel(y0), .fetch_en(fe0),
    .h_sync(hs0), .v_sync(vs0), .de(de0),
    .frame_start(fs0), .line_start(ls0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LAT(5), .CW(4)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .restart(restart),
    .x_pixel(x1), .y_pixel(y1), .fetch_en(fe1),
    .h_sync(hs1), .v_sync(vs1), .de(de1),
    .frame_start(fs1), .line_start(ls1), .frame_cnt(fc1)
  );

  bit          sel;
  logic [10:0] ox, oy;
  logic        ofe, ohs, ovs, ode, ofs, ols;
  logic [15:0] ofc;

  always_comb begin
    if (sel) begin
      ox = {7'b0, x1}; oy = {7'b0, y1}; ofe = fe1;
      ohs = hs1; ovs = vs1; ode = de1;
      ofs = fs1; ols = ls1; ofc = fc1;
    end else begin
      ox = x0; oy = y0; ofe = fe0;
      ohs = hs0; ovs = vs0; ode = de0;
      ofs = fs0; ols = ls0; ofc = fc0;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  // mode currently modelled
  int HA, HFP, HSY, HT, VA, VFP, VSY, VT, LT;
  bit HP, VP;

  // model: position, ticks since reset, tick of last flush
  int          mx, my, tk, base;
  bit          pend, armed;
  logic [15:0] mfc;
  int          hx[64], hy[64];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic use_cfg(input bit s);
    sel = s;
    if (!s) begin
      HA = MODE_640x480_60.h_active; HFP = MODE_640x480_60.h_fp;
      HSY = MODE_640x480_60.h_sync;  HT = 800;
      VA = MODE_640x480_60.v_active; VFP = MODE_640x480_60.v_fp;
      VSY = MODE_640x480_60.v_sync;  VT = 525;
      HP = 1'b0; VP = 1'b0; LT = 2;
    end else begin
      HA = 8; HFP = 2; HSY = 3; HT = 15;
      VA = 6; VFP = 2; VSY = 2; VT = 11;
      HP = 1'b1; VP = 1'b1; LT = 5;
    end
  endtask

  function automatic logic [4:0] dec(int x, int y);
    logic hs, vs, d, fs, ls;
    hs = (x >= HA + HFP && x < HA + HFP + HSY) ? HP : !HP;
    vs = (y >= VA + VFP && y < VA + VFP + VSY) ? VP : !VP;
    d  = (x < HA) && (y < VA);
    fs = (x == 0) && (y == 0);
    ls = (x == 0) && (y < VA);
    return {hs, vs, d, fs, ls};
  endfunction

  task automatic model_check();
    logic [4:0] e;
    int k;
    if (tk >= base + LT) begin
      k = (tk - LT) % 64;
      e = dec(hx[k], hy[k]);
    end else begin
      e = {!HP, !VP, 3'b000};
    end
    chk("x", longint'(ox), longint'(mx));
    chk("y", longint'(oy), longint'(my));
    chk("fetch_en", longint'(ofe), longint'(mx < HA && my < VA));
    chk("h_sync", longint'(ohs), longint'(e[4]));
    chk("v_sync", longint'(ovs), longint'(e[3]));
    chk("de", longint'(ode), longint'(e[2]));
    chk("frame_start", longint'(ofs), longint'(e[1] & pix_en));
    chk("line_start", longint'(ols), longint'(e[0] & pix_en));
    chk("frame_cnt", longint'(ofc), longint'(mfc));
  endtask

  task automatic upd(input bit rst, input bit pe, input bit rs);
    if (rst) begin
      mx = 0; my = 0; mfc = '0; tk = 0; base = 0;
      pend = 1'b0; armed = 1'b1; hx[0] = 0; hy[0] = 0;
    end else if (pe) begin
      if (rs || pend) begin
        mx = 0; my = 0; base = tk + 1;
      end else begin
        mx++;
        if (mx == HT) begin
          mx = 0; my++;
          if (my == VT) begin my = 0; mfc++; end
        end
      end
      pend = 1'b0;
      tk++;
      hx[tk % 64] = mx;
      hy[tk % 64] = my;
    end else if (rs) begin
      pend = 1'b1;
    end
  endtask

  // drive, model-check at negedge, update model at posedge, return at +1
  task automatic step(input bit rst, input bit pe, input bit rs);
    reset = rst; pix_en = pe; restart = rs;
    @(negedge clk);
    if (!rst && armed) model_check();
    @(posedge clk);
    upd(rst, pe, rs);
    #1;
  endtask

  typedef struct {
    bit rst, pe, rs;
    int x, y;
    bit hs, de;
  } vec_t;

  vec_t tv[12];

  initial begin
    int tx, tf, len, dcnt, n;
    bit prev;
    logic [15:0] fsav;
    reset = 1'b1; pix_en = 1'b0; restart = 1'b0;
    armed = 1'b0; sel = 1'b0;
    @(posedge clk); #1;

    // default mode, LAT=2: reset, hold, pending and same-cycle restart
    tv[0]  = '{1, 0, 0, 0, 0, 1, 0};
    tv[1]  = '{0, 1, 0, 1, 0, 1, 0};
    tv[2]  = '{0, 1, 0, 2, 0, 1, 1};
    tv[3]  = '{0, 0, 0, 2, 0, 1, 1};
    tv[4]  = '{0, 0, 1, 2, 0, 1, 1};
    tv[5]  = '{0, 1, 0, 0, 0, 1, 0};
    tv[6]  = '{0, 1, 0, 1, 0, 1, 0};
    tv[7]  = '{0, 1, 0, 2, 0, 1, 1};
    tv[8]  = '{0, 1, 1, 0, 0, 1, 0};
    tv[9]  = '{1, 1, 1, 0, 0, 1, 0};
    tv[10] = '{0, 0, 0, 0, 0, 1, 0};
    tv[11] = '{0, 1, 0, 1, 0, 1, 0};
    use_cfg(1'b0);
    for (int i = 0; i < 12; i++) begin
      step(tv[i].rst, tv[i].pe, tv[i].rs);
      chk($sformatf("tv%0d.x", i), longint'(ox), longint'(tv[i].x));
      chk($sformatf("tv%0d.y", i), longint'(oy), longint'(tv[i].y));
      chk($sformatf("tv%0d.hs", i), longint'(ohs), longint'(tv[i].hs));
      chk($sformatf("tv%0d.de", i), longint'(ode), longint'(tv[i].de));
      chk($sformatf("tv%0d.fc", i), longint'(ofc), 0);
    end

    // default mode, full-rate: h_sync placement/width, de per line
    step(1'b1, 1'b0, 1'b0);
    tx = -1; tf = -1; len = 0; dcnt = 0; prev = 1'b1;
    for (int t = 1; t <= 1700; t++) begin
      step(1'b0, 1'b1, 1'b0);
      if (ox == 11'd656 && tx < 0) tx = t;
      if (tf < 0 && prev && !ohs) tf = t;
      if (tf >= 0 && t < tf + 200 && !ohs) len++;
      if (t <= 1600 && ode) dcnt++;
      prev = ohs;
    end
    chk("hs_start_lag", longint'(tf - tx), 2);
    chk("hs_width", longint'(len), 96);
    chk("de_two_lines", longint'(dcnt), 1280);

    // small mode, 1-in-4 ticks with occasional restart
    use_cfg(1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++)
      step(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);

    // de lags fetch_en by LAT=5 ticks; sync idles low
    step(1'b1, 1'b0, 1'b0);
    chk("rst_fetch_en", longint'(ofe), 1);
    chk("rst_hs_idle", longint'(ohs), 0);
    chk("rst_vs_idle", longint'(ovs), 0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (ode && n == 0) n = i;
    end
    chk("de_lag", longint'(n), 5);

    // restart mid-frame at (4,3)
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 49; i++) step(1'b0, 1'b1, 1'b0);
    chk("pre_rs_x", longint'(ox), 4);
    chk("pre_rs_y", longint'(oy), 3);
    fsav = ofc;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("rs_x", longint'(ox), 0);
    chk("rs_y", longint'(oy), 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rs_de%0d", i), longint'(ode), 0);
      chk($sformatf("rs_hs%0d", i), longint'(ohs), 0);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("rs_de_back", longint'(ode), 1);
    chk("rs_fc", longint'(ofc), longint'(fsav));

    // reset while inside v_sync
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 131; i++) step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_vs", longint'(ovs), 1);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_x", longint'(ox), 0);
    chk("rst_y", longint'(oy), 0);
    chk("rst_hs", longint'(ohs), 0);
    chk("rst_vs", longint'(ovs), 0);
    chk("rst_de", longint'(ode), 0);
    chk("rst_fc", longint'(ofc), 0);

    // three frames, then wrap 0xFFFF -> 0
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 495; i++) step(1'b0, 1'b1, 1'b0);
    chk("fc_three", longint'(ofc), 3);
    force dut1.frame_cnt = 16'hFFFF;
    #1;
    release dut1.frame_cnt;
    mfc = 16'hFFFF;
    step(1'b0, 1'b0, 1'b0);
    chk("fc_forced", longint'(ofc), 16'hFFFF);
    for (int i = 0; i < 164; i++) step(1'b0, 1'b1, 1'b0);
    chk("fc_pre_wrap", longint'(ofc), 16'hFFFF);
    step(1'b0, 1'b1, 1'b0);
    chk("fc_wrap", longint'(ofc), 0);
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
